// File: rtl/adder_chk_pkg.sv
// Shared types and widths for the 4-bit adder response checker.
// Holds the FSM state encoding and the captured-operand record.
package adder_chk_pkg;

    localparam int OPW  = 4;
    localparam int CNTW = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } chk_state_e;

    typedef struct packed {
        logic [OPW-1:0] a;
        logic [OPW-1:0] b;
        logic           cin;
    } operand_t;

endpackage

// File: rtl/adder_ref_4bit.sv
// Golden 4-bit adder: a + b + c_in at full 5-bit width, purely combinational.
module adder_ref_4bit
    import adder_chk_pkg::*;
(
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    input  logic           c_in,
    output logic [OPW:0]   result
);

    assign result = {1'b0, a} + {1'b0, b} + {{OPW{1'b0}}, c_in};

endmodule

// File: rtl/adder_resp_checker.sv
// Checks an external 4-bit adder over a run of NUM_SAMPLES valid samples,
// counting mismatches and capturing the operands of the first failure.
module adder_resp_checker
    import adder_chk_pkg::*;
#(
    parameter int NUM_SAMPLES = 100,
    parameter int ERR_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              valid,
    input  logic [OPW-1:0]    a,
    input  logic [OPW-1:0]    b,
    input  logic              c_in,
    input  logic [OPW-1:0]    sum,
    input  logic              carry,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [CNTW-1:0]   sample_count,
    output logic              fail_valid,
    output logic [OPW-1:0]    fail_a,
    output logic [OPW-1:0]    fail_b,
    output logic              fail_cin
);

    chk_state_e     state, state_nxt;
    logic [OPW:0]   exp_res;
    logic           mismatch;
    logic           accept;
    logic           launch;
    logic           last;
    operand_t       fail_q;

    adder_ref_4bit u_ref (
        .a      (a),
        .b      (b),
        .c_in   (c_in),
        .result (exp_res)
    );

    assign mismatch = ({carry, sum} != exp_res);
    assign accept   = (state == ST_RUN) && valid;
    assign launch   = (state != ST_RUN) && start;
    assign last     = (sample_count == CNTW'(NUM_SAMPLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: if (start) state_nxt = ST_RUN;
            ST_RUN:           if (valid && last) state_nxt = ST_DONE;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    // Counters and capture clear on the run-launch edge so DONE holds last results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_count <= '0;
            err_count    <= '0;
            fail_valid   <= 1'b0;
            fail_q       <= '0;
        end else if (launch) begin
            sample_count <= '0;
            err_count    <= '0;
            fail_valid   <= 1'b0;
            fail_q       <= '0;
        end else if (accept) begin
            sample_count <= sample_count + 1'b1;
            if (mismatch) begin
                if (!(&err_count)) err_count <= err_count + 1'b1;
                if (!fail_valid) begin
                    fail_valid <= 1'b1;
                    fail_q     <= '{a: a, b: b, cin: c_in};
                end
            end
        end
    end

    assign busy     = (state == ST_RUN);
    assign done     = (state == ST_DONE);
    assign pass     = (state == ST_DONE) && (err_count == '0);
    assign fail_a   = fail_q.a;
    assign fail_b   = fail_q.b;
    assign fail_cin = fail_q.cin;

endmodule

// File: tb/tb_adder_resp_checker.sv
// Randomised and directed bench for adder_resp_checker, two parameterisations.
module tb_adder_resp_checker;

    localparam int N1 = 100, E1 = 8;
    localparam int N2 = 20,  E2 = 2;

    logic clk = 1'b0;
    logic rst, start, valid, c_in, carry;
    logic [3:0] a, b, sum;

    logic       busy1, done1, pass1, fv1, fc1;
    logic [7:0] err1;
    logic [8:0] cnt1;
    logic [3:0] fa1, fb1;
    logic       busy2, done2, pass2, fv2, fc2;
    logic [1:0] err2;
    logic [8:0] cnt2;
    logic [3:0] fa2, fb2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    adder_resp_checker #(.NUM_SAMPLES(N1), .ERR_W(E1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .valid(valid), .a(a), .b(b),
        .c_in(c_in), .sum(sum), .carry(carry), .busy(busy1), .done(done1),
        .pass(pass1), .err_count(err1), .sample_count(cnt1), .fail_valid(fv1),
        .fail_a(fa1), .fail_b(fb1), .fail_cin(fc1));

    adder_resp_checker #(.NUM_SAMPLES(N2), .ERR_W(E2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .valid(valid), .a(a), .b(b),
        .c_in(c_in), .sum(sum), .carry(carry), .busy(busy2), .done(done2),
        .pass(pass2), .err_count(err2), .sample_count(cnt2), .fail_valid(fv2),
        .fail_a(fa2), .fail_b(fb2), .fail_cin(fc2));

    typedef struct packed {
        bit run; bit dn; int cnt; int err; bit fv; int fa; int fb; int fc;
    } model_t;

    model_t m1, m2;

    function automatic model_t mreset();
        model_t m;
        m.run = 0; m.dn = 0; m.cnt = 0; m.err = 0;
        m.fv = 0; m.fa = 0; m.fb = 0; m.fc = 0;
        return m;
    endfunction

    function automatic model_t mstep(model_t m, int n, int emax, bit st, bit v,
                                     int ia, int ib, int ic, int ires);
        model_t r = m;
        if (!m.run) begin
            if (st) begin
                r = mreset();
                r.run = 1;
            end
        end else if (v) begin
            r.cnt = m.cnt + 1;
            if (ia + ib + ic != ires) begin
                if (r.err < emax) r.err = r.err + 1;
                if (!r.fv) begin
                    r.fv = 1; r.fa = ia; r.fb = ib; r.fc = ic;
                end
            end
            if (r.cnt == n) begin
                r.run = 0;
                r.dn  = 1;
            end
        end
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m1 <= mreset();
            m2 <= mreset();
        end else begin
            m1 <= mstep(m1, N1, 2**E1 - 1, start, valid, a, b, c_in, {carry, sum});
            m2 <= mstep(m2, N2, 2**E2 - 1, start, valid, a, b, c_in, {carry, sum});
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("m1.busy", busy1, m1.run);
        chk("m1.done", done1, m1.dn);
        chk("m1.pass", pass1, m1.dn && m1.err == 0);
        chk("m1.err",  err1,  m1.err);
        chk("m1.cnt",  cnt1,  m1.cnt);
        chk("m1.fv",   fv1,   m1.fv);
        chk("m1.fa",   fa1,   m1.fa);
        chk("m1.fb",   fb1,   m1.fb);
        chk("m1.fc",   fc1,   m1.fc);
        chk("m2.busy", busy2, m2.run);
        chk("m2.done", done2, m2.dn);
        chk("m2.pass", pass2, m2.dn && m2.err == 0);
        chk("m2.err",  err2,  m2.err);
        chk("m2.cnt",  cnt2,  m2.cnt);
        chk("m2.fv",   fv2,   m2.fv);
        chk("m2.fa",   fa2,   m2.fa);
        chk("m2.fb",   fb2,   m2.fb);
        chk("m2.fc",   fc2,   m2.fc);
    end

    // Drive one cycle with an explicit 5-bit adder response, then step past the edge.
    task automatic drive_raw(input bit st, input bit v, input int ia, input int ib,
                             input int ic, input int res);
        logic [4:0] r5;
        r5    = 5'(res);
        start = st; valid = v;
        a = 4'(ia); b = 4'(ib); c_in = 1'(ic);
        {carry, sum} = r5;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit st, input bit v, input int ia, input int ib,
                         input int ic, input int xmask);
        drive_raw(st, v, ia, ib, ic, (ia + ib + ic) ^ xmask);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".busy"}, busy1, 0);
        chk({tag, ".done"}, done1, 0);
        chk({tag, ".pass"}, pass1, 0);
        chk({tag, ".err"},  err1,  0);
        chk({tag, ".cnt"},  cnt1,  0);
        chk({tag, ".fv"},   fv1,   0);
        chk({tag, ".fa"},   fa1,   0);
        chk({tag, ".fb"},   fb1,   0);
        chk({tag, ".fc"},   fc1,   0);
    endtask

    initial begin
        int ra, rb, rc, res;
        rst = 1'b1; start = 0; valid = 0; a = 0; b = 0; c_in = 0; sum = 0; carry = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_reset_vals("reset");

        // start and valid together in IDLE: transition only
        drive(1, 1, 5, 6, 1, 0);
        chk("sv.cnt", cnt1, 0);
        chk("sv.busy", busy1, 1);

        // clean sweep, correct adder
        do_reset();
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 100; i++) drive(0, 1, i % 16, (i / 16 + i) % 16, (i >> 2) & 1, 0);
        chk("sweep.done", done1, 1);
        chk("sweep.pass", pass1, 1);
        chk("sweep.err",  err1,  0);
        chk("sweep.cnt",  cnt1,  100);
        chk("sweep.fv",   fv1,   0);
        drive(0, 0, 0, 0, 0, 0);
        chk("sweep.hold", cnt1, 100);

        // sum bit 0 stuck low from sample 10
        do_reset();
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 100; i++) begin
            if (i == 10) begin ra = 3; rb = 4; rc = 0; end
            else begin ra = $urandom_range(15); rb = $urandom_range(15); rc = $urandom_range(1); end
            res = ra + rb + rc;
            if (i >= 10) res = res & 30;
            drive_raw(0, 1, ra, rb, rc, res);
        end
        chk("stuck.fa", fa1, 3);
        chk("stuck.fb", fb1, 4);
        chk("stuck.fc", fc1, 0);
        chk("stuck.fv", fv1, 1);
        chk("stuck.pass", pass1, 0);
        chk("stuck.done", done1, 1);

        // boundary 15+15+1
        do_reset();
        drive(1, 0, 0, 0, 0, 0);
        drive_raw(0, 1, 15, 15, 1, 31);
        chk("bnd.ok.err", err1, 0);
        drive_raw(0, 1, 15, 15, 1, 15);
        chk("bnd.bad.err", err1, 1);
        chk("bnd.bad.fa", fa1, 15);

        // carry wrong for 10 samples: 2-bit counter saturates
        do_reset();
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            drive(0, 1, $urandom_range(15), $urandom_range(15), $urandom_range(1), 16);
        chk("sat.err2", err2, 3);
        chk("sat.err1", err1, 10);
        chk("sat.cnt2", cnt2, 10);

        // async reset mid-run
        do_reset();
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 50; i++) drive(0, 1, i % 16, 15 - i % 16, i & 1, (i == 5) ? 1 : 0);
        #2 rst = 1'b1;
        #1;
        chk_reset_vals("midrst");
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) drive(0, 1, 1, 2, 0, 0);
        chk("postrst.cnt", cnt1, 0);
        chk("postrst.busy", busy1, 0);
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 1, 2, 3, 1, 0);
        chk("restart.cnt", cnt1, 5);

        // 1-in-3 valid with start pulses during RUN
        do_reset();
        drive(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 300; k++)
            drive((k % 7) == 3, (k % 3) == 0, $urandom_range(15), $urandom_range(15),
                  $urandom_range(1), ($urandom_range(9) == 0) ? 2 : 0);
        chk("gap.cnt", cnt1, 100);
        chk("gap.done", done1, 1);

        // random soak
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(499) == 0) do_reset();
            drive($urandom_range(19) == 0, $urandom_range(3) != 0, $urandom_range(15),
                  $urandom_range(15), $urandom_range(1),
                  ($urandom_range(3) == 0) ? (1 << $urandom_range(4)) : 0);
        end
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
